reg_wb_writer: RTL and testbench



---
 rtl/reg_wb_writer.sv | 134 +++++++++++++
 tb/tb_reg_wb_writer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reg_wb_writer.sv
// rtl/reg_wb_writer.sv - register-file write port merging ALU results with a queued mul/div stream
// Optional WB_STATS_EN adds saturating wr_cnt / kill_cnt statistics outputs.
module reg_wb_writer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic [4:0]  chk_reg,
  output logic        chk_pending,
`ifdef WB_STATS_EN
  output logic [15:0] wr_cnt,
  output logic [15:0] kill_cnt,
`endif
  output logic        reg_write_en,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [7:0]       starve_cnt;

  logic empty, full, head_live, starve;
  logic alu_acc, alu_wr, push, push_store, push_killed, pop, pop_live;

  always_comb begin
    empty       = (count == '0);
    full        = (count == (AW+1)'(DEPTH));
    head_live   = !empty && q_live[rd_ptr];
    starve      = head_live && (starve_cnt >= 8'(STARVE_LIMIT));
    alu_ready   = !starve;
    md_ready    = !full;
    alu_acc     = alu_valid && alu_ready;
    alu_wr      = alu_acc && (alu_rd != 5'd0);
    push        = md_valid && md_ready;
    push_store  = push && (md_rd != 5'd0);
    // A same-cycle md result is older than the ALU result, so it dies on arrival.
    push_killed = push_store && alu_wr && (md_rd == alu_rd);
    pop         = !alu_wr && !empty;
    pop_live    = pop && head_live;
  end

  always_comb begin
    chk_pending = push_store && !push_killed && (md_rd == chk_reg);
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i] && (q_rd[i] == chk_reg)) chk_pending = 1'b1;
    end
    if (chk_reg == 5'd0) chk_pending = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_live       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      starve_cnt   <= '0;
      reg_write_en <= 1'b0;
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_wr && (q_rd[i] == alu_rd)) q_live[i] <= 1'b0;
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      // Never aliases the popped slot: a pop with a push implies not full.
      if (push_store) begin
        q_rd[wr_ptr]   <= md_rd;
        q_data[wr_ptr] <= md_data;
        q_live[wr_ptr] <= !push_killed;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (push_store && !pop)      count <= count + 1'b1;
      else if (!push_store && pop) count <= count - 1'b1;

      if (empty || pop)   starve_cnt <= '0;
      else if (head_live) starve_cnt <= starve_cnt + 8'd1;

      reg_write_en <= alu_wr || pop_live;
      if (alu_wr) begin
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (pop_live) begin
        write_reg  <= q_rd[rd_ptr];
        write_data <= q_data[rd_ptr];
      end
    end
  end

`ifdef WB_STATS_EN
  logic [5:0]  kill_inc;
  logic [16:0] wr_sum, kill_sum;

  always_comb begin
    kill_inc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_wr && q_live[i] && (q_rd[i] == alu_rd)) kill_inc = kill_inc + 6'd1;
    end
    if (alu_acc && (alu_rd == 5'd0)) kill_inc = kill_inc + 6'd1;
    if (push && (md_rd == 5'd0))     kill_inc = kill_inc + 6'd1;
    if (push_killed)                 kill_inc = kill_inc + 6'd1;
    wr_sum   = {1'b0, wr_cnt} + {16'd0, reg_write_en};
    kill_sum = {1'b0, kill_cnt} + {11'd0, kill_inc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      kill_cnt <= '0;
    end else begin
      wr_cnt   <= wr_sum[16]   ? 16'hFFFF : wr_sum[15:0];
      kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_writer.sv
// tb/tb_reg_wb_writer.sv - scoreboard bench for reg_wb_writer
// Expected writes are queued as stimulus is driven and popped whenever reg_write_en is seen.
module tb_reg_wb_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, md_valid = 1'b0;
  logic        alu_ready, md_ready, chk_pending, reg_write_en;
  logic [4:0]  alu_rd = '0, md_rd = '0, chk_reg = '0, write_reg;
  logic [31:0] alu_data = '0, md_data = '0, write_data;
`ifdef WB_STATS_EN
  logic [15:0] wr_cnt, kill_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  reg_wb_writer #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .chk_reg(chk_reg), .chk_pending(chk_pending),
`ifdef WB_STATS_EN
    .wr_cnt(wr_cnt), .kill_cnt(kill_cnt),
`endif
    .reg_write_en(reg_write_en), .write_reg(write_reg), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    md_valid  = 1'b0;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reg_write_en === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", {27'd0, write_reg, write_data}, 64'd0);
      else check("sb_write", {27'd0, write_reg, write_data}, {27'd0, exp_q.pop_front()});
    end
  end

  initial begin
    idle();
    tick(); tick();
    @(negedge clk);
    check("rst_we", reg_write_en, 0);
    check("rst_reg", write_reg, 0);
    check("rst_data", write_data, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_md_ready", md_ready, 1);
    check("rst_pending", chk_pending, 0);
    tick(); rst_n = 1'b1;

    // ALU only, then a $0 result that must not write
    tick(); alu_valid = 1; alu_rd = 5'd1; alu_data = 32'd42; expect_write(5'd1, 32'd42);
    tick(); alu_rd = 5'd0; alu_data = 32'd99;
    @(negedge clk);
    check("alu_we", reg_write_en, 1);
    check("alu_reg", write_reg, 1);
    check("alu_data", write_data, 42);
    tick(); idle();
    @(negedge clk); check("alu_rd0_we", reg_write_en, 0);

    // md only: two-cycle write latency and pending tracking
    tick(); md_valid = 1; md_rd = 5'd5; md_data = 32'hDEAD; chk_reg = 5'd5;
    expect_write(5'd5, 32'hDEAD);
    @(negedge clk); check("md_push_pending", chk_pending, 1);
    tick(); idle();
    @(negedge clk); check("md_lat1_we", reg_write_en, 0);
    tick();
    @(negedge clk);
    check("md_lat2_we", reg_write_en, 1);
    check("md_after_pending", chk_pending, 0);
    tick();
    @(negedge clk); check("md_idle_we", reg_write_en, 0);

    // Same-cycle kill: only the ALU value reaches $7
    tick(); md_valid = 1; md_rd = 5'd7; md_data = 32'd1;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'd2; chk_reg = 5'd7;
    expect_write(5'd7, 32'd2);
    tick(); idle();
    @(negedge clk); check("kill_pending", chk_pending, 0);
    tick();
    @(negedge clk); check("kill_silent_pop", reg_write_en, 0);
    tick(); tick();

    // Fill the FIFO while the ALU is busy, then drain in order
    for (int i = 0; i < 4; i++) begin
      tick();
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(100 + i);
      md_valid = 1;  md_rd = 5'(20 + i);  md_data = 32'(200 + i);
      expect_write(alu_rd, alu_data);
      @(negedge clk); check("fill_md_ready", md_ready, 1);
    end
    tick();
    alu_rd = 5'd14; alu_data = 32'd104; md_rd = 5'd24; md_data = 32'd204;
    expect_write(5'd14, 32'd104);
    @(negedge clk);
    check("full_md_ready", md_ready, 0);
    check("full_alu_ready", alu_ready, 1);
    for (int i = 0; i < 4; i++) expect_write(5'(20 + i), 32'(200 + i));
    tick(); idle();
    repeat (6) tick();
    check("full_drained", exp_q.size(), 0);

    // Starvation: head waits 8 cycles, then ALU is back-pressured for one
    for (int c = 0; c < 12; c++) begin
      tick();
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'(c);
      md_valid = (c == 0); md_rd = 5'd9; md_data = 32'h900;
      @(negedge clk);
      check("starve_alu_ready", alu_ready, (c != 9));
      if (c != 9) expect_write(5'd3, 32'(c));
      else        expect_write(5'd9, 32'h900);
    end
    tick(); idle();
    repeat (3) tick();
    check("starve_drained", exp_q.size(), 0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      tick();
      alu_valid = 1; alu_rd = 5'd11; alu_data = 32'(300 + i);
      md_valid = 1;  md_rd = 5'd12;  md_data = 32'(400 + i);
      expect_write(alu_rd, alu_data);
    end
    tick(); idle(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; chk_reg = 5'd12;
    @(negedge clk);
    check("mid_rst_we", reg_write_en, 0);
    check("mid_rst_md_ready", md_ready, 1);
    check("mid_rst_pending", chk_pending, 0);
    repeat (5) begin
      tick();
      @(negedge clk); check("post_rst_quiet", reg_write_en, 0);
    end
    tick(); alu_valid = 1; alu_rd = 5'd2; alu_data = 32'd77; expect_write(5'd2, 32'd77);
    tick(); idle();
    @(negedge clk); check("post_rst_alu", {write_reg, write_data}, {5'd2, 32'd77});
    repeat (2) tick();
    check("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
